// File: rtl/pll_rst_pkg.sv
// Shared types and sizing helpers for the PLL bring-up sequencer.
// State encodings are exported on the debug port, so their values are fixed.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // The shared cycle counter only ever counts to (largest period - 1).
    function automatic int cnt_width(input int por, input int stable,
                                     input int timeout, input int gap);
        int m;
        m = por;
        if (stable  > m) m = stable;
        if (timeout > m) m = timeout;
        if (gap     > m) m = gap;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level input.
// It is reused for other asynchronous inputs, so it has no design-specific logic.
module bit_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up controller: pulses the PLL reset, waits for stable lock, then
// releases the per-domain resets one at a time and watches for lock loss.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int POR_CYCLES          = 50,
    parameter int LOCK_STABLE_CYCLES  = 5000,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int NUM_DOMAINS         = 8,
    parameter int STAGE_GAP_CYCLES    = 16
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   all_ready,
    output logic [2:0]             state_o,
    output logic [RETRY_W-1:0]     retry_cnt,
    output logic [LOSS_W-1:0]      loss_cnt
);

    localparam int CW    = cnt_width(POR_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CW-1:0]    POR_T  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0]    STB_T  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    TMO_T  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]    GAP_T  = CW'(STAGE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_D = IDX_W'(NUM_DOMAINS - 1);

    state_t                 state, state_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [IDX_W-1:0]       idx, idx_d;
    logic [NUM_DOMAINS-1:0] dom_d;
    logic [RETRY_W-1:0]     retry_d;
    logic [LOSS_W-1:0]      loss_d;
    logic                   pll_rst_d, all_ready_d;
    logic                   lock_s;

    bit_sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PLL_RST;
            cnt       <= '0;
            idx       <= '0;
            dom_rst   <= '1;
            pll_rst   <= 1'b1;
            all_ready <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            dom_rst   <= dom_d;
            pll_rst   <= pll_rst_d;
            all_ready <= all_ready_d;
            retry_cnt <= retry_d;
            loss_cnt  <= loss_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state;
        cnt_d   = cnt + CW'(1);
        idx_d   = idx;
        dom_d   = dom_rst;
        retry_d = retry_cnt;
        loss_d  = loss_cnt;
        unique case (state)
            PLL_RST: begin
                dom_d = '1;
                idx_d = '0;
                if (cnt == POR_T) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle still wins.
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt == TMO_T) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    if (retry_cnt != '1) retry_d = retry_cnt + RETRY_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt == STB_T) begin
                    cnt_d    = '0;
                    dom_d[0] = 1'b0;
                    if (NUM_DOMAINS == 1) begin
                        state_d = RUN;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            RELEASE, RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    dom_d   = '1;
                    if (loss_cnt != '1) loss_d = loss_cnt + LOSS_W'(1);
                end else if (state == RUN) begin
                    cnt_d = cnt;
                end else if (cnt == GAP_T) begin
                    cnt_d      = '0;
                    dom_d[idx] = 1'b0;
                    idx_d      = idx + IDX_W'(1);
                    if (idx == LAST_D) state_d = RUN;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
                dom_d   = '1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        pll_rst_d   = (state_d == PLL_RST);
        all_ready_d = (state_d == RUN);
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: expected output-change events are queued as stimulus is
// scheduled and matched, in order and by cycle, as the outputs change.
module tb_pll_reset_sequencer;

    localparam int POR = 4;
    localparam int STB = 8;
    localparam int TMO = 20;
    localparam int ND  = 3;
    localparam int GAP = 2;

    logic          refclk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          pll_rst;
    logic [ND-1:0] dom_rst;
    logic          all_ready;
    logic [2:0]    state_o;
    logic [3:0]    retry_cnt;
    logic [7:0]    loss_cnt;

    pll_reset_sequencer #(
        .POR_CYCLES          (POR),
        .LOCK_STABLE_CYCLES  (STB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .NUM_DOMAINS         (ND),
        .STAGE_GAP_CYCLES    (GAP)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .dom_rst    (dom_rst),
        .all_ready  (all_ready),
        .state_o    (state_o),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #10 refclk = ~refclk;

    typedef struct {
        int         cyc;
        logic [7:0] out;
    } ev_t;

    ev_t        sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;
    logic [7:0] prev;

    always @(posedge refclk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] snap(input logic p, input logic [2:0] d,
                                        input logic r, input logic [2:0] s);
        return {p, d, r, s};
    endfunction

    task automatic push(input int c, input logic [7:0] o);
        ev_t e;
        e.cyc = c;
        e.out = o;
        sb.push_back(e);
    endtask

    // RELEASE entry at rl clears bit 0; n further stages follow every GAP cycles.
    task automatic push_release(input int rl, input int n);
        logic [2:0] d;
        logic [2:0] ones;
        bit         last;
        ones = 3'b111;
        push(rl, snap(1'b0, 3'b110, 1'b0, 3'd3));
        for (int k = 1; k <= n; k++) begin
            d    = ones << (k + 1);
            last = (k == ND - 1);
            push(rl + k * GAP, snap(1'b0, d, last, last ? 3'd4 : 3'd3));
        end
    endtask

    // PLL_RST entered at edge e with lock already present by WAIT_LOCK.
    task automatic push_bringup(input int e, input int n);
        push(e + POR,     snap(1'b0, 3'b111, 1'b0, 3'd1));
        push(e + POR + 1, snap(1'b0, 3'b111, 1'b0, 3'd2));
        push_release(e + POR + 1 + STB, n);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    task automatic drain(input int c);
        wait_until(c);
        check("sb_drained", sb.size(), 0);
    endtask

    always @(negedge refclk) begin
        logic [7:0] cur;
        ev_t        e;
        cur = snap(pll_rst, dom_rst, all_ready, state_o);
        if (mon_en && cur !== prev) begin
            if (sb.size() == 0) begin
                check("ev_unexpected", 32'(cur), 32'(prev));
            end else begin
                e = sb.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_outputs", 32'(cur), 32'(e.out));
            end
        end
        prev = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d, e, s, t, p, w;
        rst        = 1'b1;
        pll_locked = 1'b1;
        @(negedge refclk);

        // Reset values, then bring-up with lock tied high
        wait_until(3);
        check("rst_pll_rst",   32'(pll_rst),   1);
        check("rst_dom_rst",   32'(dom_rst),   7);
        check("rst_all_ready", 32'(all_ready), 0);
        check("rst_state",     32'(state_o),   0);
        check("rst_retry",     32'(retry_cnt), 0);
        check("rst_loss",      32'(loss_cnt),  0);
        rst    = 1'b0;
        mon_en = 1'b1;
        push_bringup(3, ND - 1);
        drain(3 + POR + 1 + STB + (ND - 1) * GAP + 4);
        check("run_state", 32'(state_o),   4);
        check("run_retry", 32'(retry_cnt), 0);
        check("run_loss",  32'(loss_cnt),  0);

        // Lock dropped 3 cycles in RUN, then again just after the first release
        d = cyc;
        e = d + 3;
        pll_locked = 1'b0;
        push(e, snap(1'b1, 3'b111, 1'b0, 3'd0));
        push_bringup(e, 1);
        push(e + 16, snap(1'b1, 3'b111, 1'b0, 3'd0));
        push_bringup(e + 16, ND - 1);
        wait_until(e);
        pll_locked = 1'b1;
        check("loss_after_run_drop", 32'(loss_cnt), 1);
        wait_until(e + 13);
        check("dom_first_release", 32'(dom_rst), 6);
        pll_locked = 1'b0;
        wait_until(e + 14);
        pll_locked = 1'b1;
        wait_until(e + 16);
        check("loss_after_release_drop", 32'(loss_cnt), 2);
        drain(e + 16 + POR + 1 + STB + (ND - 1) * GAP + 4);

        // One-cycle rst in RUN clears everything and restarts
        s = cyc + 1;
        push(s, snap(1'b1, 3'b111, 1'b0, 3'd0));
        push_bringup(s, ND - 1);
        rst = 1'b1;
        wait_until(s);
        rst = 1'b0;
        check("rst_run_state", 32'(state_o),   0);
        check("rst_run_retry", 32'(retry_cnt), 0);
        check("rst_run_loss",  32'(loss_cnt),  0);
        drain(s + POR + 1 + STB + (ND - 1) * GAP + 4);

        // Lock held low: timeout loop with saturating retry count
        t = cyc + 1;
        push(t, snap(1'b1, 3'b111, 1'b0, 3'd0));
        rst        = 1'b1;
        pll_locked = 1'b0;
        wait_until(t);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            p = t + (POR + TMO) * (k - 1);
            push(p + POR,       snap(1'b0, 3'b111, 1'b0, 3'd1));
            push(p + POR + TMO, snap(1'b1, 3'b111, 1'b0, 3'd0));
            wait_until(p + POR + TMO);
            check("retry_cnt", 32'(retry_cnt), (k < 15) ? k : 15);
        end

        // Lock arrives on the timeout cycle, then a one-cycle glitch in STABLE
        p = t + 16 * (POR + TMO);
        w = p + POR + TMO;
        push(p + POR, snap(1'b0, 3'b111, 1'b0, 3'd1));
        push(w,       snap(1'b0, 3'b111, 1'b0, 3'd2));
        push(w + 6,   snap(1'b0, 3'b111, 1'b0, 3'd1));
        push(w + 7,   snap(1'b0, 3'b111, 1'b0, 3'd2));
        push_release(w + 7 + STB, ND - 1);
        wait_until(w - 3);
        pll_locked = 1'b1;
        wait_until(w + 3);
        pll_locked = 1'b0;
        wait_until(w + 4);
        pll_locked = 1'b1;
        wait_until(w + 1);
        check("lock_wins_retry", 32'(retry_cnt), 15);
        drain(w + 7 + STB + (ND - 1) * GAP + 4);
        check("glitch_loss",      32'(loss_cnt),  0);
        check("glitch_all_ready", 32'(all_ready), 1);
        check("glitch_dom_rst",   32'(dom_rst),   0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
